// File: rtl/mem_arbiter_if.sv
// Requester-side bundle for mem_arbiter: request, grant and read-return signals
// for both ports. The master modport is the requesters' view, the slave modport
// is the arbiter's view.
interface mem_arbiter_if #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
);

  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [AWIDTH-1:0] addr0;
  logic [AWIDTH-1:0] addr1;
  logic [DWIDTH-1:0] wdata0;
  logic [DWIDTH-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DWIDTH-1:0] rdata;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and sequencer for a single-port memory with a
// shared bidirectional data bus. Port 0 is the CPU path, port 1 the loader.
// Accesses are serialised one per cycle, and a dead (turnaround) cycle is
// inserted whenever a write would directly follow a read, so the memory and
// the arbiter never drive the data bus at the same time.
module mem_arbiter #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  mem_arbiter_if.slave      bus,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [AWIDTH-1:0] mem_addr,
  inout  wire  [DWIDTH-1:0] mem_data
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    TURN
  } state_t;

  state_t            state;
  logic              ptr;
  logic              pend_port;
  logic [DWIDTH-1:0] wdata_q;

  logic              elig0;
  logic              elig1;
  logic              win_valid;
  logic              win_port;
  logic              win_we;
  logic [AWIDTH-1:0] win_addr;
  logic [DWIDTH-1:0] win_wdata;

  // Pick this edge's winner: the frozen port while turning the bus around,
  // otherwise the single eligible port or, on contention, the one ptr names.
  always_comb begin
    elig0     = bus.req0 & ~bus.gnt0;
    elig1     = bus.req1 & ~bus.gnt1;
    win_valid = 1'b0;
    win_port  = 1'b0;
    if (state == TURN) begin
      win_valid = 1'b1;
      win_port  = pend_port;
    end else begin
      win_valid = elig0 | elig1;
      win_port  = (elig0 & elig1) ? ptr : elig1;
    end
    win_we    = win_port ? bus.we1    : bus.we0;
    win_addr  = win_port ? bus.addr1  : bus.addr0;
    win_wdata = win_port ? bus.wdata1 : bus.wdata0;
  end

  // Sequencer: captures read data, then issues the next access, parks a write
  // behind a turnaround cycle when the bus is still carrying read data, or idles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= 1'b0;
      pend_port   <= 1'b0;
      wdata_q     <= '0;
      mem_wr      <= 1'b0;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      bus.gnt0    <= 1'b0;
      bus.gnt1    <= 1'b0;
      bus.rvalid0 <= 1'b0;
      bus.rvalid1 <= 1'b0;
      bus.rdata   <= '0;
    end else begin
      bus.rvalid0 <= mem_rd & bus.gnt0;
      bus.rvalid1 <= mem_rd & bus.gnt1;
      if (mem_rd) begin
        bus.rdata <= mem_data;
      end

      if (win_valid && win_we && mem_rd) begin
        state     <= TURN;
        pend_port <= win_port;
        mem_wr    <= 1'b0;
        mem_rd    <= 1'b0;
        bus.gnt0  <= 1'b0;
        bus.gnt1  <= 1'b0;
      end else if (win_valid) begin
        state     <= ACCESS;
        mem_addr  <= win_addr;
        mem_wr    <= win_we;
        mem_rd    <= ~win_we;
        wdata_q   <= win_wdata;
        bus.gnt0  <= ~win_port;
        bus.gnt1  <= win_port;
        ptr       <= ~win_port;
      end else begin
        state     <= IDLE;
        mem_wr    <= 1'b0;
        mem_rd    <= 1'b0;
        bus.gnt0  <= 1'b0;
        bus.gnt1  <= 1'b0;
      end
    end
  end

  assign mem_data = mem_wr ? wdata_q : {DWIDTH{1'bz}};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. A behavioural single-port memory sits on
// the shared bus; every step advances one clock and compares DUT outputs with
// hand-computed values.
module tb_mem_arbiter;

  logic       clk;
  logic       rst;
  logic       mem_wr;
  logic       mem_rd;
  logic [4:0] mem_addr;
  wire  [7:0] mem_data;

  logic [7:0] mem [0:31];
  logic [7:0] exp_mem [0:31];

  int total;
  int passed;
  int failed;

  mem_arbiter_if #(.AWIDTH(5), .DWIDTH(8)) bus ();

  mem_arbiter #(.AWIDTH(5), .DWIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .mem_wr   (mem_wr),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .mem_data (mem_data)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural memory: loads 0x40+addr on reset, commits writes at the edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'(8'h40 + i);
    end else if (mem_wr) begin
      mem[mem_addr] <= mem_data;
    end
  end

  assign mem_data = mem_rd ? mem[mem_addr] : 8'bzzzzzzzz;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int port, input logic req, input logic we,
                                input logic [4:0] addr, input logic [7:0] wdata);
    if (port == 0) begin
      bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
    end else begin
      bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // The memory and the arbiter must never both be driving the bus.
  always @(negedge clk) begin
    if (!rst) check_output("bus_conflict", 32'(mem_wr & mem_rd), 32'd0);
  end

  initial begin
    int i0, i1, j, r;
    logic pend, prev_rd;
    logic [7:0] exp_rd;
    total = 0; passed = 0; failed = 0;
    rst = 1'b1;
    apply_stimulus(0, 1'b1, 1'b0, 5'd2, 8'h00);
    apply_stimulus(1, 1'b1, 1'b0, 5'd3, 8'h00);

    $display("[TB] reset with both requests held");
    tick;
    check_output("rst_gnt0", 32'(bus.gnt0), 32'd0);
    check_output("rst_gnt1", 32'(bus.gnt1), 32'd0);
    check_output("rst_rvalid", 32'({bus.rvalid0, bus.rvalid1}), 32'd0);
    check_output("rst_mem_wr_rd", 32'({mem_wr, mem_rd}), 32'd0);
    check_output("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_output("rst_rdata", 32'(bus.rdata), 32'd0);
    tick;
    check_output("rst2_gnt", 32'({bus.gnt0, bus.gnt1}), 32'd0);
    rst = 1'b0;
    tick;
    check_output("first_gnt0", 32'(bus.gnt0), 32'd1);
    check_output("first_gnt1", 32'(bus.gnt1), 32'd0);
    check_output("first_rd", 32'(mem_rd), 32'd1);
    check_output("first_addr", 32'(mem_addr), 32'd2);
    apply_stimulus(0, 1'b0, 1'b0, 5'd0, 8'h00);
    tick;
    check_output("second_gnt1", 32'(bus.gnt1), 32'd1);
    check_output("second_gnt0", 32'(bus.gnt0), 32'd0);
    check_output("rvalid0_a", 32'(bus.rvalid0), 32'd1);
    check_output("rdata_a", 32'(bus.rdata), 32'h42);
    check_output("second_addr", 32'(mem_addr), 32'd3);
    apply_stimulus(1, 1'b0, 1'b0, 5'd0, 8'h00);
    tick;
    check_output("rvalid1_a", 32'(bus.rvalid1), 32'd1);
    check_output("rvalid0_clr", 32'(bus.rvalid0), 32'd0);
    check_output("rdata_b", 32'(bus.rdata), 32'h43);
    check_output("idle_gnt", 32'({bus.gnt0, bus.gnt1}), 32'd0);

    $display("[TB] single-port write then read");
    apply_stimulus(0, 1'b1, 1'b1, 5'd0, 8'hFF);
    tick;
    check_output("wr_gnt0", 32'(bus.gnt0), 32'd1);
    check_output("wr_mem_wr", 32'({mem_wr, mem_rd}), 32'b10);
    check_output("wr_addr", 32'(mem_addr), 32'd0);
    check_output("wr_data", 32'(mem_data), 32'hFF);
    apply_stimulus(0, 1'b1, 1'b0, 5'd0, 8'h00);
    tick;
    check_output("masked_gnt0", 32'(bus.gnt0), 32'd0);
    check_output("masked_idle", 32'({mem_wr, mem_rd}), 32'd0);
    tick;
    check_output("rd_gnt0", 32'(bus.gnt0), 32'd1);
    check_output("rd_mem_rd", 32'({mem_wr, mem_rd}), 32'b01);
    apply_stimulus(0, 1'b0, 1'b0, 5'd0, 8'h00);
    tick;
    check_output("rd_rvalid0", 32'(bus.rvalid0), 32'd1);
    check_output("rd_rdata", 32'(bus.rdata), 32'hFF);

    // ptr now names port 1 (last grant went to port 0), so port 1 leads.
    $display("[TB] contention, both ports writing");
    i0 = 0; i1 = 0;
    apply_stimulus(0, 1'b1, 1'b1, 5'd0, 8'h00);
    apply_stimulus(1, 1'b1, 1'b1, 5'd16, 8'h80);
    for (int c = 0; c < 32; c++) begin
      tick;
      check_output("cont_gnt1", 32'(bus.gnt1), 32'((c % 2) == 0));
      check_output("cont_gnt0", 32'(bus.gnt0), 32'((c % 2) == 1));
      check_output("cont_wr", 32'(mem_wr), 32'd1);
      if (bus.gnt1) begin
        check_output("cont_addr1", 32'(mem_addr), 32'(16 + i1));
        check_output("cont_data1", 32'(mem_data), 32'(8'h80 + i1));
        i1++;
        if (i1 < 16) apply_stimulus(1, 1'b1, 1'b1, 5'(16 + i1), 8'(8'h80 + i1));
        else apply_stimulus(1, 1'b0, 1'b0, 5'd0, 8'h00);
      end
      if (bus.gnt0) begin
        check_output("cont_addr0", 32'(mem_addr), 32'(i0));
        check_output("cont_data0", 32'(mem_data), 32'(i0));
        i0++;
        if (i0 < 16) apply_stimulus(0, 1'b1, 1'b1, 5'(i0), 8'(i0));
        else apply_stimulus(0, 1'b0, 1'b0, 5'd0, 8'h00);
      end
    end
    tick;
    check_output("cont_done", 32'({bus.gnt0, bus.gnt1}), 32'd0);
    for (int a = 0; a < 32; a++) begin
      exp_mem[a] = (a < 16) ? 8'(a) : 8'(8'h80 + a - 16);
      check_output("cont_readback", 32'(mem[a]), 32'(exp_mem[a]));
    end

    $display("[TB] read followed by write to address 31");
    apply_stimulus(1, 1'b1, 1'b0, 5'd31, 8'h00);
    apply_stimulus(0, 1'b1, 1'b1, 5'd31, 8'h5A);
    tick;
    check_output("ta_gnt1", 32'({bus.gnt0, bus.gnt1}), 32'b01);
    check_output("ta_rd", 32'({mem_wr, mem_rd}), 32'b01);
    check_output("ta_addr", 32'(mem_addr), 32'd31);
    apply_stimulus(1, 1'b0, 1'b0, 5'd0, 8'h00);
    tick;
    check_output("ta_turn_gnt", 32'({bus.gnt0, bus.gnt1}), 32'd0);
    check_output("ta_turn_bus", 32'({mem_wr, mem_rd}), 32'd0);
    check_output("ta_rvalid1", 32'(bus.rvalid1), 32'd1);
    check_output("ta_rdata_old", 32'(bus.rdata), 32'h8F);
    tick;
    check_output("ta_gnt0", 32'({bus.gnt0, bus.gnt1}), 32'b10);
    check_output("ta_wr", 32'({mem_wr, mem_rd}), 32'b10);
    check_output("ta_wdata", 32'(mem_data), 32'h5A);
    check_output("ta_rdata_hold", 32'(bus.rdata), 32'h8F);
    apply_stimulus(0, 1'b1, 1'b0, 5'd31, 8'h00);
    tick;
    check_output("ta_masked", 32'(bus.gnt0), 32'd0);
    tick;
    check_output("ta_rd2_gnt0", 32'(bus.gnt0), 32'd1);
    apply_stimulus(0, 1'b0, 1'b0, 5'd0, 8'h00);
    tick;
    check_output("ta_rd2_rvalid0", 32'(bus.rvalid0), 32'd1);
    check_output("ta_rd2_rdata", 32'(bus.rdata), 32'h5A);
    exp_mem[31] = 8'h5A;

    $display("[TB] sweep: port 1 writes, port 0 reads back");
    j = 0; r = 0; pend = 1'b0; prev_rd = 1'b0; exp_rd = 8'h00;
    apply_stimulus(1, 1'b1, 1'b1, 5'd31, 8'h00);
    apply_stimulus(0, 1'b1, 1'b0, 5'd31, 8'h00);
    for (int c = 0; c < 200 && (j < 31 || r < 31 || pend); c++) begin
      tick;
      if (pend) begin
        check_output("sw_rvalid0", 32'(bus.rvalid0), 32'd1);
        check_output("sw_rdata", 32'(bus.rdata), 32'(exp_rd));
        pend = 1'b0;
      end
      if (mem_wr) check_output("sw_turnaround", 32'(prev_rd), 32'd0);
      if (bus.gnt1) begin
        check_output("sw_wr_addr", 32'(mem_addr), 32'(31 - j));
        check_output("sw_wr_data", 32'(mem_data), 32'(j));
        exp_mem[31 - j] = 8'(j);
        j++;
        if (j < 31) apply_stimulus(1, 1'b1, 1'b1, 5'(31 - j), 8'(j));
        else apply_stimulus(1, 1'b0, 1'b0, 5'd0, 8'h00);
      end
      if (bus.gnt0) begin
        check_output("sw_rd_addr", 32'(mem_addr), 32'(31 - r));
        exp_rd = exp_mem[31 - r];
        pend = 1'b1;
        r++;
        if (r < 31) apply_stimulus(0, 1'b1, 1'b0, 5'(31 - r), 8'h00);
        else apply_stimulus(0, 1'b0, 1'b0, 5'd0, 8'h00);
      end
      prev_rd = mem_rd;
    end
    check_output("sw_completed", 32'({j[7:0], r[7:0], 7'd0, pend}), 32'({8'd31, 8'd31, 8'd0}));

    $display("[TB] reset during a port 1 read");
    tick;
    apply_stimulus(1, 1'b1, 1'b0, 5'd5, 8'h00);
    tick;
    check_output("mr_gnt1", 32'(bus.gnt1), 32'd1);
    check_output("mr_rd", 32'(mem_rd), 32'd1);
    rst = 1'b1;
    tick;
    check_output("mr_rvalid1", 32'(bus.rvalid1), 32'd0);
    check_output("mr_rdata", 32'(bus.rdata), 32'd0);
    check_output("mr_gnt", 32'({bus.gnt0, bus.gnt1}), 32'd0);
    check_output("mr_bus", 32'({mem_wr, mem_rd}), 32'd0);
    check_output("mr_addr", 32'(mem_addr), 32'd0);
    rst = 1'b0;
    apply_stimulus(0, 1'b1, 1'b0, 5'd6, 8'h00);
    tick;
    check_output("mr_ptr_gnt0", 32'({bus.gnt0, bus.gnt1}), 32'b10);
    apply_stimulus(0, 1'b0, 1'b0, 5'd0, 8'h00);
    tick;
    check_output("mr_gnt1_again", 32'(bus.gnt1), 32'd1);
    check_output("mr_rdata0", 32'(bus.rdata), 32'h46);
    apply_stimulus(1, 1'b0, 1'b0, 5'd0, 8'h00);
    tick;
    check_output("mr_rvalid1_again", 32'(bus.rvalid1), 32'd1);
    check_output("mr_rdata1", 32'(bus.rdata), 32'h45);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
